// File: rtl/ibex_pkg.sv
// Shared types for the writeback queue stage.
package ibex_pkg;

    // Writeback instruction class; LOAD/STORE wait for an LSU response before retiring.
    typedef enum logic [1:0] {
        WB_INSTR_LOAD  = 2'b00,
        WB_INSTR_STORE = 2'b01,
        WB_INSTR_OTHER = 2'b10
    } wb_instr_type_e;

    // Largest supported number of in-flight writeback entries.
    localparam int unsigned WB_DEPTH_MAX = 8;

endpackage

// File: rtl/ibex_wb_queue_stage.sv
// Writeback queue: a circular buffer of in-flight instructions that retire in order,
// performing the register file write and reporting RAW hazards back to ID.
module ibex_wb_queue_stage
    import ibex_pkg::*;
#(
    parameter int unsigned WbDepth = 2,
    parameter bit          FpRfEn  = 1'b1
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,

    input  logic                         en_wb_i,
    input  wb_instr_type_e               instr_type_wb_i,
    input  logic [31:0]                  pc_id_i,
    input  logic                         instr_is_compressed_id_i,
    input  logic                         instr_perf_count_id_i,

    input  logic [4:0]                   rf_waddr_id_i,
    input  logic [31:0]                  rf_wdata_id_i,
    input  logic                         rf_we_id_i,
    input  logic                         rf_fp_id_i,

    input  logic [31:0]                  rf_wdata_lsu_i,
    input  logic                         lsu_resp_valid_i,
    input  logic                         lsu_resp_err_i,

    input  logic [4:0]                   rf_raddr_a_i,
    input  logic [4:0]                   rf_raddr_b_i,
    input  logic                         rf_rfp_a_i,
    input  logic                         rf_rfp_b_i,

    output logic                         ready_wb_o,
    output logic                         hazard_a_o,
    output logic                         hazard_b_o,
    output logic                         outstanding_load_wb_o,
    output logic                         outstanding_store_wb_o,
    output logic [$clog2(WbDepth+1)-1:0] wb_count_o,

    output logic [4:0]                   rf_waddr_wb_o,
    output logic [31:0]                  rf_wdata_wb_o,
    output logic                         rf_we_wb_o,
    output logic                         fp_we_wb_o,

    output logic [31:0]                  pc_wb_o,
    output logic                         instr_done_wb_o,
    output logic                         perf_instr_ret_wb_o,
    output logic                         perf_instr_ret_compressed_wb_o
);

    localparam int unsigned PtrW = (WbDepth > 1) ? $clog2(WbDepth) : 1;
    localparam int unsigned CntW = $clog2(WbDepth + 1);

    typedef logic [PtrW-1:0] ptr_t;

    function automatic ptr_t ptr_inc(ptr_t p);
        return (p == ptr_t'(WbDepth - 1)) ? '0 : p + ptr_t'(1);
    endfunction

    // Control state
    ptr_t               head_q, head_d;
    ptr_t               tail_q, tail_d;
    logic [CntW-1:0]    count_q, count_d;
    logic [WbDepth-1:0] valid_q, valid_d;

    // Entry payload (no reset; qualified by valid_q)
    wb_instr_type_e type_q   [WbDepth];
    logic [31:0]    pc_q     [WbDepth];
    logic           comp_q   [WbDepth];
    logic           perf_q   [WbDepth];
    logic [4:0]     waddr_q  [WbDepth];
    logic [31:0]    wdata_q  [WbDepth];
    logic           we_q     [WbDepth];
    logic           fp_q     [WbDepth];

    logic           head_valid;
    wb_instr_type_e head_type;
    logic           retire;
    logic           enq;
    logic           wr_en;
    logic           int_we;
    logic           fp_we;
    logic [31:0]    wr_data;

    assign head_valid = valid_q[head_q];
    assign head_type  = type_q[head_q];

    // OTHER retires on its first head cycle; memory ops wait for the LSU response.
    assign retire = head_valid & ((head_type == WB_INSTR_OTHER) | lsu_resp_valid_i);

    // A full queue still accepts when the head leaves in the same cycle.
    assign ready_wb_o = (count_q < CntW'(WbDepth)) | retire;
    assign enq        = en_wb_i & ready_wb_o;

    // Register file write for the retiring head entry
    always_comb begin
        wr_en   = retire & we_q[head_q] &
                  ((head_type == WB_INSTR_OTHER) |
                   ((head_type == WB_INSTR_LOAD) & ~lsu_resp_err_i));
        wr_data = (head_type == WB_INSTR_LOAD) ? rf_wdata_lsu_i : wdata_q[head_q];
        // x0 is hard-wired zero; f0 is a real register.
        int_we  = wr_en & ~fp_q[head_q] & (waddr_q[head_q] != 5'd0);
        fp_we   = wr_en & fp_q[head_q] & FpRfEn;
    end

    assign rf_we_wb_o    = int_we;
    assign fp_we_wb_o    = fp_we;
    assign rf_waddr_wb_o = (int_we | fp_we) ? waddr_q[head_q] : 5'd0;
    assign rf_wdata_wb_o = (int_we | fp_we) ? wr_data : 32'd0;

    assign pc_wb_o         = head_valid ? pc_q[head_q] : 32'd0;
    assign instr_done_wb_o = retire;
    assign perf_instr_ret_wb_o =
        retire & perf_q[head_q] & ~(lsu_resp_valid_i & lsu_resp_err_i);
    assign perf_instr_ret_compressed_wb_o = perf_instr_ret_wb_o & comp_q[head_q];
    assign wb_count_o = count_q;

    // RAW hazard and outstanding memory-op scan over all valid entries
    always_comb begin
        hazard_a_o             = 1'b0;
        hazard_b_o             = 1'b0;
        outstanding_load_wb_o  = 1'b0;
        outstanding_store_wb_o = 1'b0;
        for (int i = 0; i < int'(WbDepth); i++) begin
            if (valid_q[i]) begin
                if ((we_q[i] | (type_q[i] == WB_INSTR_LOAD)) &&
                    (waddr_q[i] == rf_raddr_a_i) && (fp_q[i] == rf_rfp_a_i) &&
                    (fp_q[i] | (rf_raddr_a_i != 5'd0))) begin
                    hazard_a_o = 1'b1;
                end
                if ((we_q[i] | (type_q[i] == WB_INSTR_LOAD)) &&
                    (waddr_q[i] == rf_raddr_b_i) && (fp_q[i] == rf_rfp_b_i) &&
                    (fp_q[i] | (rf_raddr_b_i != 5'd0))) begin
                    hazard_b_o = 1'b1;
                end
                if (type_q[i] == WB_INSTR_LOAD)  outstanding_load_wb_o  = 1'b1;
                if (type_q[i] == WB_INSTR_STORE) outstanding_store_wb_o = 1'b1;
            end
        end
    end

    // Pointer, valid and occupancy next state
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        valid_d = valid_q;
        if (retire) begin
            valid_d[head_q] = 1'b0;
            head_d          = ptr_inc(head_q);
        end
        // Enqueue after retire so full+retire+enqueue on head==tail keeps the slot valid.
        if (enq) begin
            valid_d[tail_q] = 1'b1;
            tail_d          = ptr_inc(tail_q);
        end
        if (enq && !retire) begin
            count_d = count_q + CntW'(1);
        end else if (!enq && retire) begin
            count_d = count_q - CntW'(1);
        end
    end

    // Control state registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            valid_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            valid_q <= valid_d;
        end
    end

    // Payload capture at the tail on enqueue
    always_ff @(posedge clk_i) begin
        if (enq) begin
            type_q[tail_q]  <= instr_type_wb_i;
            pc_q[tail_q]    <= pc_id_i;
            comp_q[tail_q]  <= instr_is_compressed_id_i;
            perf_q[tail_q]  <= instr_perf_count_id_i;
            waddr_q[tail_q] <= rf_waddr_id_i;
            wdata_q[tail_q] <= rf_wdata_id_i;
            we_q[tail_q]    <= rf_we_id_i;
            fp_q[tail_q]    <= rf_fp_id_i;
        end
    end

`ifndef SYNTHESIS
    // A reset can orphan one in-flight LSU response; tolerate it until the first response.
    logic orphan_ok_q, orphan_ok_d;

    // Orphan-response allowance next state
    always_comb begin
        orphan_ok_d = orphan_ok_q;
        if (lsu_resp_valid_i) orphan_ok_d = 1'b0;
    end

    // Orphan-response allowance register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) orphan_ok_q <= 1'b1;
        else         orphan_ok_q <= orphan_ok_d;
    end

    a_one_rf_write: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(rf_we_wb_o && fp_we_wb_o))
        else $error("integer and FP RF writes asserted together");

    a_count_bound: assert property (@(posedge clk_i) disable iff (!rst_ni)
        count_q <= CntW'(WbDepth))
        else $error("occupancy exceeds depth");

    a_lsu_resp_expected: assert property (@(posedge clk_i) disable iff (!rst_ni)
        lsu_resp_valid_i |-> (outstanding_load_wb_o || outstanding_store_wb_o ||
                              orphan_ok_q))
        else $error("LSU response with no memory op outstanding");
`endif

endmodule

// File: tb/tb_ibex_wb_queue_stage.sv
// Directed, table-driven bench for the writeback queue (WbDepth=2, FpRfEn=1).
module tb_ibex_wb_queue_stage;
    import ibex_pkg::*;

    typedef struct packed {
        logic           en;
        wb_instr_type_e itype;
        logic [31:0]    pc;
        logic           comp;
        logic           perf;
        logic [4:0]     waddr;
        logic [31:0]    wdata;
        logic           we;
        logic           fp;
        logic [31:0]    lsu_wdata;
        logic           lsu_valid;
        logic           lsu_err;
        logic [4:0]     ra;
        logic           rfp_a;
        logic [4:0]     rb;
        logic           rfp_b;
    } in_t;

    typedef struct packed {
        logic        ready;
        logic        haz_a;
        logic        haz_b;
        logic        out_ld;
        logic        out_st;
        logic [1:0]  count;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic        we;
        logic        fp_we;
        logic [31:0] pc;
        logic        done;
        logic        perf;
        logic        perf_c;
    } out_t;

    typedef struct {
        string name;
        in_t   i;
        out_t  o;
    } vec_t;

    logic           clk = 1'b0;
    logic           rst_n = 1'b1;
    logic           en_wb;
    wb_instr_type_e instr_type;
    logic [31:0]    pc_id;
    logic           comp_id, perf_id;
    logic [4:0]     waddr_id;
    logic [31:0]    wdata_id;
    logic           we_id, fp_id;
    logic [31:0]    lsu_wdata;
    logic           lsu_valid, lsu_err;
    logic [4:0]     raddr_a, raddr_b;
    logic           rfp_a, rfp_b;

    logic           ready_wb, hazard_a, hazard_b, out_ld, out_st;
    logic [1:0]     wb_count;
    logic [4:0]     waddr_wb;
    logic [31:0]    wdata_wb, pc_wb;
    logic           we_wb, fp_we_wb, done_wb, perf_wb, perf_c_wb;

    int n_vec = 0;
    int n_err = 0;
    vec_t vecs[$];

    always #5 clk = ~clk;

    ibex_wb_queue_stage #(.WbDepth(2), .FpRfEn(1'b1)) dut (
        .clk_i                          (clk),
        .rst_ni                         (rst_n),
        .en_wb_i                        (en_wb),
        .instr_type_wb_i                (instr_type),
        .pc_id_i                        (pc_id),
        .instr_is_compressed_id_i       (comp_id),
        .instr_perf_count_id_i          (perf_id),
        .rf_waddr_id_i                  (waddr_id),
        .rf_wdata_id_i                  (wdata_id),
        .rf_we_id_i                     (we_id),
        .rf_fp_id_i                     (fp_id),
        .rf_wdata_lsu_i                 (lsu_wdata),
        .lsu_resp_valid_i               (lsu_valid),
        .lsu_resp_err_i                 (lsu_err),
        .rf_raddr_a_i                   (raddr_a),
        .rf_raddr_b_i                   (raddr_b),
        .rf_rfp_a_i                     (rfp_a),
        .rf_rfp_b_i                     (rfp_b),
        .ready_wb_o                     (ready_wb),
        .hazard_a_o                     (hazard_a),
        .hazard_b_o                     (hazard_b),
        .outstanding_load_wb_o          (out_ld),
        .outstanding_store_wb_o         (out_st),
        .wb_count_o                     (wb_count),
        .rf_waddr_wb_o                  (waddr_wb),
        .rf_wdata_wb_o                  (wdata_wb),
        .rf_we_wb_o                     (we_wb),
        .fp_we_wb_o                     (fp_we_wb),
        .pc_wb_o                        (pc_wb),
        .instr_done_wb_o                (done_wb),
        .perf_instr_ret_wb_o            (perf_wb),
        .perf_instr_ret_compressed_wb_o (perf_c_wb)
    );

    function automatic in_t i_idle();
        in_t i = '0;
        i.itype = WB_INSTR_OTHER;
        return i;
    endfunction

    function automatic in_t i_enq(wb_instr_type_e t, logic [4:0] a, logic [31:0] d,
                                  logic we, logic fp, logic [31:0] pc, logic comp);
        in_t i = i_idle();
        i.en = 1'b1; i.itype = t; i.waddr = a; i.wdata = d; i.we = we; i.fp = fp;
        i.pc = pc; i.comp = comp; i.perf = 1'b1;
        return i;
    endfunction

    function automatic out_t o_st(logic rdy, logic [1:0] cnt, logic ld, logic st,
                                  logic [31:0] pc);
        out_t o = '0;
        o.ready = rdy; o.count = cnt; o.out_ld = ld; o.out_st = st; o.pc = pc;
        return o;
    endfunction

    function automatic out_t o_ret(out_t b, logic perf, logic perf_c);
        out_t o = b;
        o.done = 1'b1; o.perf = perf; o.perf_c = perf_c;
        return o;
    endfunction

    function automatic out_t o_wr(out_t b, logic fp, logic [4:0] a, logic [31:0] d);
        out_t o = b;
        o.we = ~fp; o.fp_we = fp; o.waddr = a; o.wdata = d;
        return o;
    endfunction

    task automatic add(string name, in_t i, out_t o);
        vec_t v;
        v.name = name; v.i = i; v.o = o;
        vecs.push_back(v);
    endtask

    task automatic apply(in_t i);
        en_wb = i.en; instr_type = i.itype; pc_id = i.pc; comp_id = i.comp;
        perf_id = i.perf; waddr_id = i.waddr; wdata_id = i.wdata; we_id = i.we;
        fp_id = i.fp; lsu_wdata = i.lsu_wdata; lsu_valid = i.lsu_valid;
        lsu_err = i.lsu_err; raddr_a = i.ra; rfp_a = i.rfp_a; raddr_b = i.rb;
        rfp_b = i.rfp_b;
    endtask

    task automatic check(string name, out_t exp);
        out_t act;
        act = {ready_wb, hazard_a, hazard_b, out_ld, out_st, wb_count, waddr_wb, wdata_wb,
               we_wb, fp_we_wb, pc_wb, done_wb, perf_wb, perf_c_wb};
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive at negedge, compare 1 time unit later, well before the next rising edge.
    task automatic step(string name, in_t i, out_t o);
        @(negedge clk);
        apply(i);
        #1;
        check(name, o);
    endtask

    initial begin
        in_t  vi;
        out_t vo;

        // Back-to-back OTHER writes
        add("idle0", i_idle(), o_st(1, 0, 0, 0, 0));
        add("enq_x5", i_enq(WB_INSTR_OTHER, 5, 32'h11, 1, 0, 32'h100, 0), o_st(1, 0, 0, 0, 0));
        add("wr_x5", i_enq(WB_INSTR_OTHER, 6, 32'h22, 1, 0, 32'h104, 0),
            o_wr(o_ret(o_st(1, 1, 0, 0, 32'h100), 1, 0), 0, 5, 32'h11));
        add("wr_x6", i_enq(WB_INSTR_OTHER, 7, 32'h33, 1, 0, 32'h108, 0),
            o_wr(o_ret(o_st(1, 1, 0, 0, 32'h104), 1, 0), 0, 6, 32'h22));
        vi = i_idle(); vi.ra = 7; vi.rb = 6;
        vo = o_wr(o_ret(o_st(1, 1, 0, 0, 32'h108), 1, 0), 0, 7, 32'h33); vo.haz_a = 1'b1;
        add("wr_x7_haz", vi, vo);
        add("empty1", i_idle(), o_st(1, 0, 0, 0, 0));

        // LOAD blocks the queue until its response
        add("enq_ld_x8", i_enq(WB_INSTR_LOAD, 8, 0, 1, 0, 32'h200, 0), o_st(1, 0, 0, 0, 0));
        vi = i_enq(WB_INSTR_OTHER, 9, 32'h5, 1, 0, 32'h204, 0); vi.ra = 8;
        vo = o_st(1, 1, 1, 0, 32'h200); vo.haz_a = 1'b1;
        add("ld_wait", vi, vo);
        vi = i_enq(WB_INSTR_OTHER, 11, 32'h77, 1, 0, 32'h208, 0); vi.rb = 9;
        vo = o_st(0, 2, 1, 0, 32'h200); vo.haz_b = 1'b1;
        add("full_stall", vi, vo);
        vi = i_enq(WB_INSTR_OTHER, 11, 32'h77, 1, 0, 32'h208, 0);
        vi.lsu_valid = 1'b1; vi.lsu_wdata = 32'hCAFE;
        add("ld_resp_x8", vi, o_wr(o_ret(o_st(1, 2, 1, 0, 32'h200), 1, 0), 0, 8, 32'hCAFE));
        add("wr_x9", i_idle(), o_wr(o_ret(o_st(1, 2, 0, 0, 32'h204), 1, 0), 0, 9, 32'h5));
        add("wr_x11", i_idle(), o_wr(o_ret(o_st(1, 1, 0, 0, 32'h208), 1, 0), 0, 11, 32'h77));
        add("empty2", i_idle(), o_st(1, 0, 0, 0, 0));

        // FP loads: error suppresses write and perf; f0 is writable
        add("enq_ld_f3", i_enq(WB_INSTR_LOAD, 3, 0, 1, 1, 32'h300, 1), o_st(1, 0, 0, 0, 0));
        vi = i_idle(); vi.lsu_valid = 1'b1; vi.lsu_err = 1'b1; vi.lsu_wdata = 32'hDEAD;
        vi.ra = 3; vi.rfp_a = 1'b1; vi.rb = 3; vi.rfp_b = 1'b0;
        vo = o_ret(o_st(1, 1, 1, 0, 32'h300), 0, 0); vo.haz_a = 1'b1;
        add("ld_f3_err", vi, vo);
        add("enq_ld_f0", i_enq(WB_INSTR_LOAD, 0, 0, 1, 1, 32'h304, 1), o_st(1, 0, 0, 0, 0));
        vi = i_idle(); vi.lsu_valid = 1'b1; vi.lsu_wdata = 32'h1234;
        add("ld_f0_wr", vi, o_wr(o_ret(o_st(1, 1, 1, 0, 32'h304), 1, 1), 1, 0, 32'h1234));

        // Hazard RF select and x0 handling
        add("enq_x10", i_enq(WB_INSTR_OTHER, 10, 32'hAA, 1, 0, 32'h400, 0), o_st(1, 0, 0, 0, 0));
        vi = i_idle(); vi.ra = 10; vi.rfp_a = 1'b1; vi.rb = 10; vi.rfp_b = 1'b0;
        vo = o_wr(o_ret(o_st(1, 1, 0, 0, 32'h400), 1, 0), 0, 10, 32'hAA); vo.haz_b = 1'b1;
        add("haz_rfsel", vi, vo);
        add("enq_x0", i_enq(WB_INSTR_OTHER, 0, 32'h99, 1, 0, 32'h404, 0), o_st(1, 0, 0, 0, 0));
        add("x0_supp", i_idle(), o_ret(o_st(1, 1, 0, 0, 32'h404), 1, 0));

        // STORE retires on response, no RF write
        add("enq_st", i_enq(WB_INSTR_STORE, 0, 0, 0, 0, 32'h408, 0), o_st(1, 0, 0, 0, 0));
        add("st_wait", i_idle(), o_st(1, 1, 0, 1, 32'h408));
        vi = i_idle(); vi.lsu_valid = 1'b1;
        add("st_resp", vi, o_ret(o_st(1, 1, 0, 1, 32'h408), 1, 0));
        add("empty3", i_idle(), o_st(1, 0, 0, 0, 0));

        // Response while head is OTHER must not be consumed by the LOAD behind it
        add("enq_ld_x12", i_enq(WB_INSTR_LOAD, 12, 0, 1, 0, 32'h500, 0), o_st(1, 0, 0, 0, 0));
        add("enq_x13", i_enq(WB_INSTR_OTHER, 13, 32'h13, 1, 0, 32'h504, 0),
            o_st(1, 1, 1, 0, 32'h500));
        vi = i_enq(WB_INSTR_LOAD, 14, 0, 1, 0, 32'h508, 0);
        vi.lsu_valid = 1'b1; vi.lsu_wdata = 32'hA1;
        add("ld_x12_resp", vi, o_wr(o_ret(o_st(1, 2, 1, 0, 32'h500), 1, 0), 0, 12, 32'hA1));
        vi = i_idle(); vi.lsu_valid = 1'b1; vi.lsu_wdata = 32'hB2;
        add("other_ign_resp", vi, o_wr(o_ret(o_st(1, 2, 1, 0, 32'h504), 1, 0), 0, 13, 32'h13));
        add("ld_x14_wait", i_idle(), o_st(1, 1, 1, 0, 32'h508));
        vi = i_idle(); vi.lsu_valid = 1'b1; vi.lsu_wdata = 32'hC3;
        add("ld_x14_resp", vi, o_wr(o_ret(o_st(1, 1, 1, 0, 32'h508), 1, 0), 0, 14, 32'hC3));
        add("empty4", i_idle(), o_st(1, 0, 0, 0, 0));

        // Power-on reset
        apply(i_idle());
        #2 rst_n = 1'b0;
        @(negedge clk);
        #1 check("por", o_st(1, 0, 0, 0, 0));
        rst_n = 1'b1;

        foreach (vecs[k]) step(vecs[k].name, vecs[k].i, vecs[k].o);

        // Reset mid-LOAD with a full queue
        step("fill_ld_x15", i_enq(WB_INSTR_LOAD, 15, 0, 1, 0, 32'h600, 0),
             o_st(1, 0, 0, 0, 0));
        step("fill_ld_x16", i_enq(WB_INSTR_LOAD, 16, 0, 1, 0, 32'h604, 0),
             o_st(1, 1, 1, 0, 32'h600));
        step("full_pre_rst", i_idle(), o_st(0, 2, 1, 0, 32'h600));
        @(negedge clk);
        vi = i_idle(); vi.lsu_valid = 1'b1; vi.lsu_wdata = 32'hEE;
        apply(vi);
        rst_n = 1'b0;
        #1 check("rst_mid", o_st(1, 0, 0, 0, 0));
        @(negedge clk);
        rst_n = 1'b1;
        #1 check("orphan_ign", o_st(1, 0, 0, 0, 0));
        step("post_rst", i_idle(), o_st(1, 0, 0, 0, 0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
